// File: rtl/led_blink_pkg.sv
// led_blink_pkg: shared constants, half-period type and saturating arithmetic for led_blink_multi
// Contents:
//   CLK_HZ, TICKS_PER_MS  board clock and ticks per millisecond
//   half_t                half-period register type at the default counter width
//   sat_add / sat_sub     64-bit saturating add/sub; one extra carry bit catches wrap
package led_blink_pkg;

    localparam int CLK_HZ       = 12_000_000;
    localparam int TICKS_PER_MS = CLK_HZ / 1000;
    localparam int DEF_CNT_W    = 32;

    typedef logic [DEF_CNT_W-1:0] half_t;

    // min(v + s, hi); the sum is formed one bit wider so it can never wrap
    function automatic logic [63:0] sat_add(input logic [63:0] v, input logic [63:0] s,
                                            input logic [63:0] hi);
        logic [64:0] w_sum;
        w_sum = {1'b0, v} + {1'b0, s};
        return (w_sum > {1'b0, hi}) ? hi : w_sum[63:0];
    endfunction

    // max(v - s, lo); compares v against s + lo so no negative value is ever formed
    function automatic logic [63:0] sat_sub(input logic [63:0] v, input logic [63:0] s,
                                            input logic [63:0] lo);
        return ({1'b0, v} < ({1'b0, s} + {1'b0, lo})) ? lo : v - s;
    endfunction

endpackage

// File: rtl/led_blink_multi_btn_debounce.sv
// btn_debounce: synchronise, debounce and edge-detect one raw push-button
// Ports:
//   sysclk  in   system clock
//   rst_n   in   asynchronous active-low reset
//   raw     in   raw asynchronous button level
//   level   out  debounced button level
//   press   out  one-cycle pulse on an accepted rising level
module btn_debounce #(
    parameter int DEB_TICKS = 120_000
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int DW = $clog2(DEB_TICKS + 1);

    logic [1:0]    r_sync;
    logic [DW-1:0] r_cnt;
    logic          r_level;
    logic          r_prev;
    logic          r_press;

    // r_cnt counts consecutive synchronised samples that disagree with r_level;
    // any sample that agrees again restarts the count from zero
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_prev  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], raw};
            r_prev  <= r_level;
            r_press <= r_level & ~r_prev;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DW'(DEB_TICKS - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + DW'(1);
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/led_blink_multi.sv
// led_blink_multi: multi-channel LED blinker with button-adjustable half-periods
// Ports:
//   sysclk  in   12 MHz system clock
//   rst_n   in   asynchronous active-low reset
//   btn     in   raw buttons; [0] shortens, [1] lengthens the selected half-period
//   ch_sel  in   channel receiving adjustments (out-of-range values ignored)
//   sync    in   restart every channel with its LED low
//   led     out  LED outputs, one per channel
//   half_q  out  half-period of the channel addressed by ch_sel, 0 if out of range
module led_blink_multi
    import led_blink_pkg::*;
#(
    parameter int              N_CH         = 2,
    parameter int              CNT_W        = 32,
    parameter longint unsigned HALF_DEFAULT = 6_000_000,
    parameter longint unsigned HALF_MIN     = 2,
    parameter longint unsigned HALF_MAX     = (64'd1 << CNT_W) - 64'd1,
    parameter longint unsigned STEP         = TICKS_PER_MS,
    parameter int              DEB_TICKS    = 120_000,
    localparam int             SEL_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic [1:0]       btn,
    input  logic [SEL_W-1:0] ch_sel,
    input  logic             sync,
    output logic [N_CH-1:0]  led,
    output logic [CNT_W-1:0] half_q
);

    logic [1:0]       w_press;
    logic [1:0]       w_level_unused;
    logic             w_dn;
    logic             w_up;
    logic [CNT_W-1:0] w_half [N_CH];

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_btn_dn (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .raw    (btn[0]),
        .level  (w_level_unused[0]),
        .press  (w_press[0])
    );

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_btn_up (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .raw    (btn[1]),
        .level  (w_level_unused[1]),
        .press  (w_press[1])
    );

    // simultaneous presses cancel out
    assign w_dn = w_press == 2'b01;
    assign w_up = w_press == 2'b10;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_half;
        logic             r_led;
        logic             w_sel;
        logic             w_wrap;

        assign w_sel  = 32'(ch_sel) == g;
        // cnt >= half - 1, evaluated one bit wider so half = 0 cannot underflow
        assign w_wrap = ({1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, r_half};

        always_ff @(posedge sysclk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt  <= '0;
                r_led  <= 1'b0;
                r_half <= CNT_W'(HALF_DEFAULT);
            end else begin
                if (sync) begin
                    r_cnt <= '0;
                    r_led <= 1'b0;
                end else if (w_wrap) begin
                    r_cnt <= '0;
                    r_led <= ~r_led;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_sel && w_dn)
                    r_half <= CNT_W'(sat_sub(64'(r_half), STEP, HALF_MIN));
                else if (w_sel && w_up)
                    r_half <= CNT_W'(sat_add(64'(r_half), STEP, HALF_MAX));
            end
        end

        assign led[g]    = r_led;
        assign w_half[g] = r_half;
    end

    assign half_q = (32'(ch_sel) < N_CH) ? w_half[ch_sel] : '0;

endmodule
